// File: rtl/lsu_ctrl_pkg.sv
// Shared LSU definitions: width-select indices, FSM state encoding and
// the per-width byte-enable helper.
package lsu_ctrl_pkg;
   localparam int WDTOP8       = 0;
   localparam int WDTOP16      = 1;
   localparam int WDTOP32      = 2;
   localparam int WDTOP64      = 3;
   localparam int WDT_TYPE_CNT = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } lsu_state_e;

   function automatic logic [7:0] width_mask(input logic [WDT_TYPE_CNT-1:0] wdt);
      if (wdt[WDTOP8])       width_mask = 8'h01;
      else if (wdt[WDTOP16]) width_mask = 8'h03;
      else if (wdt[WDTOP32]) width_mask = 8'h0F;
      else                   width_mask = 8'hFF;
   endfunction
endpackage

// File: rtl/lsu_ctrl_align.sv
// Combinational byte-lane logic: store data/mask placement, load extract
// with sign/zero extension, and the natural-alignment check.
module lsu_ctrl_align
   import lsu_ctrl_pkg::*;
(
   input  logic [2:0]              off_i,
   input  logic [WDT_TYPE_CNT-1:0] wdt_i,
   input  logic                    uns_i,
   input  logic                    store_i,
   input  logic [63:0]             wdata_i,
   input  logic [63:0]             rdata_i,
   output logic [7:0]              wmask_o,
   output logic [63:0]             wdata_o,
   output logic [63:0]             rdata_o,
   output logic                    misalign_o
);
   logic [5:0]  shamt;
   logic [63:0] sh;
   logic        sx;

   always_comb begin
      shamt   = {off_i, 3'b000};
      sx      = ~uns_i;
      wmask_o = store_i ? (width_mask(wdt_i) << off_i) : 8'h00;
      wdata_o = wdata_i << shamt;
      sh      = rdata_i >> shamt;
      if (wdt_i[WDTOP8])       rdata_o = {{56{sx & sh[7]}},  sh[7:0]};
      else if (wdt_i[WDTOP16]) rdata_o = {{48{sx & sh[15]}}, sh[15:0]};
      else if (wdt_i[WDTOP32]) rdata_o = {{32{sx & sh[31]}}, sh[31:0]};
      else                     rdata_o = sh;
      misalign_o = (wdt_i[WDTOP16] && off_i[0])
                || (wdt_i[WDTOP32] && (off_i[1:0] != 2'b00))
                || (wdt_i[WDTOP64] && (off_i != 3'b000));
   end
endmodule

// File: rtl/lsu_ctrl.sv
// Single-beat load/store sequencer: latches one decoded memory op, drives the
// 64-bit memory port, and returns extended load data or an error response.
module lsu_ctrl
   import lsu_ctrl_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              is_load,
   input  logic              mem_wen,
   input  logic [ADDR_W-1:0] addr,
   input  logic [63:0]       wdata,
   input  logic [3:0]        wdt_op,
   input  logic              is_unsigned,
   output logic              resp_valid,
   output logic              resp_err,
   output logic [63:0]       resp_rdata,
   output logic              core_busy,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [7:0]        mem_wmask,
   output logic [63:0]       mem_wdata,
   input  logic              mem_rsp_valid,
   input  logic [63:0]       mem_rdata
);
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   lsu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic              we_q, uns_q, err_q;
   logic [7:0]        wmask_q;
   logic [63:0]       wdata_q, rdata_q;
   logic [2:0]        off_q;
   logic [3:0]        wdt_q;
   logic [CNT_W-1:0]  cnt_q;

   logic        idle, req_err, timeout_hit, misalign;
   logic [2:0]  al_off;
   logic [3:0]  al_wdt;
   logic        al_uns;
   logic [7:0]  al_wmask;
   logic [63:0] al_wdata, al_rdata;

   // In IDLE the aligner sees the incoming request; afterwards the latched copy,
   // so one instance serves both the accept-time check and the load extract.
   assign idle   = (state_q == S_IDLE);
   assign al_off = idle ? addr[2:0]   : off_q;
   assign al_wdt = idle ? wdt_op      : wdt_q;
   assign al_uns = idle ? is_unsigned : uns_q;

   lsu_ctrl_align u_align (
      .off_i      (al_off),
      .wdt_i      (al_wdt),
      .uns_i      (al_uns),
      .store_i    (mem_wen),
      .wdata_i    (wdata),
      .rdata_i    (mem_rdata),
      .wmask_o    (al_wmask),
      .wdata_o    (al_wdata),
      .rdata_o    (al_rdata),
      .misalign_o (misalign)
   );

   assign req_err     = (is_load == mem_wen) || !$onehot(wdt_op) || misalign;
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (req_valid) state_d = req_err ? S_RESP : S_REQ;
         S_REQ:  if (mem_req_ready) state_d = S_WAIT;
         S_WAIT: if (mem_rsp_valid || timeout_hit) state_d = S_RESP;
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready     = idle;
      core_busy     = !idle || req_valid;
      mem_req_valid = (state_q == S_REQ);
      resp_valid    = (state_q == S_RESP);
      resp_err      = (state_q == S_RESP) && err_q;
      resp_rdata    = rdata_q;
      mem_addr      = addr_q;
      mem_we        = we_q;
      mem_wmask     = wmask_q;
      mem_wdata     = wdata_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         wmask_q <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         off_q   <= '0;
         wdt_q   <= '0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (req_valid) begin
                  addr_q  <= {addr[ADDR_W-1:3], 3'b000};
                  we_q    <= mem_wen;
                  uns_q   <= is_unsigned;
                  off_q   <= addr[2:0];
                  wdt_q   <= wdt_op;
                  wmask_q <= al_wmask;
                  wdata_q <= al_wdata;
                  err_q   <= req_err;
                  if (req_err) rdata_q <= '0;
               end
            end
            S_WAIT: begin
               if (mem_rsp_valid) begin
                  rdata_q <= we_q ? 64'd0 : al_rdata;
               end else if (timeout_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
